bcd_scroll_display: RTL and testbench
=====================================

// Module: bcd_scroll_display
// PURPOSE
//  Parametrised scrolling message display for the board's multiplexed 7-segment bank.
//  Holds DIGITS 4-bit hex/BCD nibbles (e.g. student ID 42024137) and rotates them one digit per scroll tick.
//  Supports selectable direction, pause, single-step and parallel reload.
//  Also time-multiplexes the digits onto shared segment lines; sits between top-level switches/buttons and board pins.
// PARAMETERS
//  CLK_HZ     100_000_000   input clock frequency
//  SCROLL_HZ  3             scroll rate; SCROLL_DIV = CLK_HZ/SCROLL_HZ (integer, >=2)
//  SCAN_HZ    1000          per-digit switch rate; SCAN_DIV = CLK_HZ/SCAN_HZ (integer, >=2)
//  DIGITS     8             digit count, 2..8; MSG_W = 4*DIGITS
//  INIT_MSG   32'h42024137  reset message, low MSG_W bits used; nibble 0 = bits [3:0]
// PORTS
//  clk          in   1      single system clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  en           in   1      1 = scroll on every scroll tick; 0 = paused (scan continues)
//  dir          in   1      0 = rotate left (nibble MSG_W-1:MSG_W-4 -> 3:0); 1 = rotate right
//  step         in   1      1-cycle pulse: rotate once immediately, honoured even when en=0
//  load         in   1      1-cycle pulse: msg <= load_data
//  load_data    in   MSG_W  new message
//  msg          out  MSG_W  current message register
//  scroll_tick  out  1      1-cycle pulse when the scroll prescaler wraps
//  an           out  DIGITS digit enables, active-low, exactly one low when running
//  seg          out  8      {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off)
// BEHAVIOUR
//  Clock/reset: one clock, clk; reset is synchronous and active-high (rst). All outputs registered.
//  Reset values: msg=INIT_MSG[MSG_W-1:0]; both prescalers=0; scan index=0; scroll_tick=0; an=all 1s; seg=8'hFF.
//  rst asserted mid-operation: everything returns to the reset values on the next edge; any pending step/load is discarded.
//  Scroll prescaler: counts 0..SCROLL_DIV-1 and wraps.
//   - scroll_tick=1 in the cycle after the count was SCROLL_DIV-1; otherwise 0.
//   - Runs regardless of en.
//  Message update, priority per edge:
//   1. rst
//   2. load: msg <= load_data
//   3. step
//   4. internal tick & en
//   - Items 3 and 4 cause ONE rotate by 4 bits in direction dir.
//   - Coincident step and tick still rotate only once.
//   - Left: msg <= {msg[MSG_W-5:0], msg[MSG_W-1:MSG_W-4]}. Right: msg <= {msg[3:0], msg[MSG_W-1:4]}.
//   - After DIGITS rotations in the same direction, msg equals its starting value.
//  Scan prescaler: counts 0..SCAN_DIV-1.
//   - On wrap, scan index advances idx -> idx+1, and DIGITS-1 wraps to 0.
//   - First advance after reset loads index 0 outputs; an and seg stay all-1s until then.
//  Digit drive: one cycle after each index change, an = ~(1<<idx) and seg = decode(msg[4*idx+3:4*idx]).
//   - Digit idx shows nibble idx; an[DIGITS-1] is the leftmost digit.
//   - The decoder samples msg live, so a scroll shows up on the next index change. No blanking between digits is required.
//  Decode: 0-9 and A-F as standard hex glyphs, e.g. 0 -> 7'b1000000 ({g..a}), 8 -> 7'b0000000, F -> 7'b0001110.
// STRUCTURE
//  Package seg7_pkg:
//   - SEG_BLANK = 8'hFF
//   - function seg7_hex(input [3:0]) -> [6:0] active-low
//   - localparam helper for divider widths ($clog2).
//  Sub-module hex_to_seg7 (combinational, wraps seg7_hex), instantiated once on the muxed nibble.
//  Top: scroll prescaler, message register, scan prescaler/index, output registers.
// TESTING (sim params CLK_HZ=24, SCROLL_HZ=3 -> div 8, SCAN_HZ=12 -> div 2, DIGITS=8)
//  Reset check: rst high for 2 cycles, then release.
//   -> msg=32'h42024137, an=8'hFF, seg=8'hFF; scroll_tick first pulses 8 cycles later.
//  Left scroll: en=1, dir=0, 1 tick -> msg=32'h20241374; 8 ticks -> back to 32'h42024137.
//  Right scroll and pause:
//   - en=1, dir=1, 1 tick -> msg=32'h74202413.
//   - en=0 over 3 ticks -> msg unchanged; one step pulse -> msg=32'h37420241.
//  Priority: load=1 with load_data=32'h12345678 in the same cycle as a tick and step -> msg=32'h12345678 exactly.
//  Scan: after reset, an walks FE, FD, ... 7F, FE, changing every 2 cycles.
//   - With an=FE, seg=8'hF8 (digit 7, dp off).
//   - With an=7F, seg=8'h99 (digit 4).
//  Mid-run reset: assert rst while an=F7 and a step is pending -> next edge all reset values; no rotation applied.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the scrolling 7-segment display: blank pattern,
// hex glyph table and a counter-width helper.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyph for one hex nibble.
  function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Bits needed to hold a counter running 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to active-low 7-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_hex(nib_i);

endmodule

// File: rtl/bcd_scroll_display.sv
// Scrolling message display: rotates a nibble message one digit per scroll
// tick (or on demand) and time-multiplexes it onto a shared 7-segment bus.
module bcd_scroll_display
  import seg7_pkg::*;
#(
  parameter int          CLK_HZ    = 100_000_000,
  parameter int          SCROLL_HZ = 3,
  parameter int          SCAN_HZ   = 1000,
  parameter int          DIGITS    = 8,
  parameter logic [31:0] INIT_MSG  = 32'h42024137
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  step,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   msg,
  output logic                  scroll_tick,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int MSG_W      = 4 * DIGITS;
  localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;
  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int SCROLL_W   = cnt_w(SCROLL_DIV);
  localparam int SCAN_W     = cnt_w(SCAN_DIV);
  localparam int IDX_W      = cnt_w(DIGITS);

  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic                scroll_tick_q, scroll_wrap;
  logic [MSG_W-1:0]    msg_q, msg_d, msg_rot;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic                scan_wrap;
  logic                started_q, started_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic [3:0]          nib;
  logic [6:0]          glyph;

  // Digit idx always shows nibble idx of the live message.
  assign nib = msg_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

  // Next-state logic for prescalers, message and scan outputs.
  always_comb begin
    scroll_wrap  = (scroll_cnt_q == SCROLL_W'(SCROLL_DIV - 1));
    scroll_cnt_d = scroll_wrap ? '0 : scroll_cnt_q + 1'b1;

    msg_rot = dir ? {msg_q[3:0], msg_q[MSG_W-1:4]}
                  : {msg_q[MSG_W-5:0], msg_q[MSG_W-1:MSG_W-4]};
    // load beats any rotation; step and an enabled tick merge into one rotate
    msg_d = msg_q;
    if (load)
      msg_d = load_data;
    else if (step || (scroll_wrap && en))
      msg_d = msg_rot;

    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    // The first scan wrap after reset only arms the outputs on index 0.
    started_d  = started_q | scan_wrap;
    idx_d      = idx_q;
    if (scan_wrap && started_q)
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    an_d  = started_q ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d = started_q ? {1'b1, glyph} : SEG_BLANK;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_cnt_q  <= '0;
      scroll_tick_q <= 1'b0;
      msg_q         <= INIT_MSG[MSG_W-1:0];
      scan_cnt_q    <= '0;
      started_q     <= 1'b0;
      idx_q         <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
    end else begin
      scroll_cnt_q  <= scroll_cnt_d;
      scroll_tick_q <= scroll_wrap;
      msg_q         <= msg_d;
      scan_cnt_q    <= scan_cnt_d;
      started_q     <= started_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign msg         = msg_q;
  assign scroll_tick = scroll_tick_q;
  assign an          = an_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_bcd_scroll_display.sv
// Directed self-checking bench for bcd_scroll_display (scroll div 8, scan div 2).
module tb_bcd_scroll_display;

  logic        clk = 1'b0;
  logic        rst, en, dir, step, load;
  logic [31:0] load_data;
  logic [31:0] msg;
  logic        scroll_tick;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks   = 0;
  int failures = 0;

  bcd_scroll_display #(
    .CLK_HZ    (24),
    .SCROLL_HZ (3),
    .SCAN_HZ   (12),
    .DIGITS    (8),
    .INIT_MSG  (32'h42024137)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dir         (dir),
    .step        (step),
    .load        (load),
    .load_data   (load_data),
    .msg         (msg),
    .scroll_tick (scroll_tick),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance until scroll_tick is seen high, bounded at 20 cycles.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (scroll_tick !== 1'b1 && n < 20);
    if (scroll_tick !== 1'b1) chk("tick_timeout", 32'(n), 32'd8);
  endtask

  initial begin
    logic [7:0] exp_an;
    int k, n;

    rst = 1'b1; en = 1'b0; dir = 1'b0; step = 1'b0; load = 1'b0;
    load_data = '0;

    // Reset for two cycles
    cyc();
    cyc();
    chk("rst_msg",  msg, 32'h42024137);
    chk("rst_an",   {24'd0, an}, 32'hFF);
    chk("rst_seg",  {24'd0, seg}, 32'hFF);
    chk("rst_tick", {31'd0, scroll_tick}, 32'd0);
    rst = 1'b0;

    // Scan walk and first scroll tick, paused so msg stays fixed
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c < 3) exp_an = 8'hFF;
      else begin
        k = ((c - 3) / 2) % 8;
        exp_an = ~(8'd1 << k);
      end
      chk($sformatf("scan_an_c%0d", c), {24'd0, an}, {24'd0, exp_an});
      chk($sformatf("tick_c%0d", c), {31'd0, scroll_tick}, {31'd0, (c % 8) == 0});
      if (c == 3 || c == 4) chk("seg_digit0", {24'd0, seg}, 32'hF8);
      if (c == 17 || c == 18) chk("seg_digit7", {24'd0, seg}, 32'h99);
    end
    chk("pause_msg0", msg, 32'h42024137);

    // Left scroll
    en = 1'b1; dir = 1'b0;
    wait_tick();
    chk("left_1", msg, 32'h20241374);
    for (int i = 0; i < 7; i++) wait_tick();
    chk("left_8", msg, 32'h42024137);

    // Right scroll
    dir = 1'b1;
    wait_tick();
    chk("right_1", msg, 32'h74202413);

    // Pause over three ticks, then single step
    en = 1'b0;
    for (int i = 0; i < 3; i++) wait_tick();
    chk("pause_3", msg, 32'h74202413);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_right", msg, 32'h37420241);

    // Load coincident with tick and step: load wins
    // (step above moved the prescaler from 0 to 1; 6 more cycles reach 7)
    for (int i = 0; i < 6; i++) cyc();
    load = 1'b1; step = 1'b1; en = 1'b1; load_data = 32'h12345678;
    cyc();
    load = 1'b0; step = 1'b0; en = 1'b0;
    chk("prio_load", msg, 32'h12345678);
    chk("prio_tick", {31'd0, scroll_tick}, 32'd1);

    // Step coincident with enabled tick rotates only once
    for (int i = 0; i < 7; i++) cyc();
    step = 1'b1; en = 1'b1; dir = 1'b1;
    cyc();
    step = 1'b0; en = 1'b0;
    chk("step_tick_once", msg, 32'h81234567);
    chk("step_tick_flag", {31'd0, scroll_tick}, 32'd1);

    // Mid-run reset while digit 3 is lit and a step is pending
    n = 0;
    while (an !== 8'hF7 && n < 40) begin
      cyc();
      n++;
    end
    chk("wait_anF7", {24'd0, an}, 32'hF7);
    rst = 1'b1; step = 1'b1;
    cyc();
    rst = 1'b0; step = 1'b0;
    chk("mid_rst_msg",  msg, 32'h42024137);
    chk("mid_rst_an",   {24'd0, an}, 32'hFF);
    chk("mid_rst_seg",  {24'd0, seg}, 32'hFF);
    chk("mid_rst_tick", {31'd0, scroll_tick}, 32'd0);
    cyc();
    chk("post_rst_an",  {24'd0, an}, 32'hFF);
    cyc();
    cyc();
    chk("post_rst_an0", {24'd0, an}, 32'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
